// File: rtl/calc_core_if.sv
// Operator/display bundle for calc_core: switch operand, opcode and ENTER
// button towards the core; result, overflow, busy and phase back out.
interface calc_core_if;
    logic [7:0] SW;
    logic [1:0] OP;
    logic       ENTER_N;
    logic [7:0] RESULT;
    logic       OVF;
    logic       BUSY;
    logic [1:0] PHASE;

    modport master (
        output SW, OP, ENTER_N,
        input  RESULT, OVF, BUSY, PHASE
    );

    modport slave (
        input  SW, OP, ENTER_N,
        output RESULT, OVF, BUSY, PHASE
    );
endinterface

// File: rtl/calc_core.sv
// calc_core: sequential signed 8-bit calculator stage. Operands are entered
// from the switches under a single ENTER button; add/sub/negate finish in one
// cycle, multiply runs as an 8-step shift-add on magnitudes. All results are
// saturated to [-128, 127] with OVF flagging the clamp.
module calc_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MUL_STEPS   = 8
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    calc_core_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MUL    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   press_s;

    logic [7:0]             a_r;
    logic [7:0]             b_r;
    logic [1:0]             op_r;
    logic [15:0]            mcand_r;
    logic [8:0]             mplr_r;
    logic [15:0]            acc_r;
    logic [3:0]             cnt_r;
    logic                   neg_r;
    logic [7:0]             result_r;
    logic                   ovf_r;

    logic [8:0]             exec_sum_s;
    logic [15:0]            acc_step_s;
    logic                   mul_last_s;
    logic [7:0]             result_s;
    logic [1:0]             phase_s;

    // Magnitude of an 8-bit two's-complement value; 9 bits so |-128| = 128.
    function automatic logic [8:0] abs9(input logic [7:0] v);
        logic [8:0] r;
        if (v[7]) begin
            r = 9'd0 - {v[7], v};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

    // Clamp a 9-bit signed value to 8 bits; returns {ovf, value}.
    function automatic logic [8:0] sat9(input logic [8:0] v);
        logic [8:0] r;
        if (v[8] == v[7]) begin
            r = {1'b0, v[7:0]};
        end else if (v[8] == 1'b0) begin
            r = {1'b1, 8'h7F};
        end else begin
            r = {1'b1, 8'h80};
        end
        return r;
    endfunction

    // Apply sign to a product magnitude and clamp; returns {ovf, value}.
    // A zero magnitude always yields +0.
    function automatic logic [8:0] sat_mag(input logic [15:0] mag, input logic neg);
        logic [8:0] r;
        if (!neg) begin
            if (mag > 16'd127) begin
                r = {1'b1, 8'h7F};
            end else begin
                r = {1'b0, mag[7:0]};
            end
        end else begin
            if (mag > 16'd128) begin
                r = {1'b1, 8'h80};
            end else begin
                r = {1'b0, 8'd0 - mag[7:0]};
            end
        end
        return r;
    endfunction

    // ENTER synchronizer plus history flop; released button is the reset value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_r <= '1;
            hist_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ENTER_N};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign press_s    = hist_r & ~sync_r[SYNC_STAGES-1];
    assign mul_last_s = (cnt_r == 4'(MUL_STEPS - 1));

    // One-cycle arithmetic for add, subtract and negate, sign-extended to 9 bits.
    always_comb begin
        exec_sum_s = 9'd0;
        case (op_r)
            2'b00:   exec_sum_s = {a_r[7], a_r} + {b_r[7], b_r};
            2'b01:   exec_sum_s = {a_r[7], a_r} - {b_r[7], b_r};
            default: exec_sum_s = 9'd0 - {a_r[7], a_r};
        endcase
    end

    // One shift-add partial product step.
    always_comb begin
        acc_step_s = acc_r;
        if (mplr_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_LOAD_A;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; presses in EXEC/MUL fall through unused.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_LOAD_A: begin
                if (press_s) next_state_s = ST_LOAD_B;
                else         next_state_s = ST_LOAD_A;
            end
            ST_LOAD_B: begin
                if (press_s) begin
                    if (bus.OP == 2'b10) next_state_s = ST_MUL;
                    else                 next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_LOAD_B;
                end
            end
            ST_EXEC: next_state_s = ST_DONE;
            ST_MUL: begin
                if (mul_last_s) next_state_s = ST_DONE;
                else            next_state_s = ST_MUL;
            end
            ST_DONE: begin
                if (press_s) next_state_s = ST_LOAD_A;
                else         next_state_s = ST_DONE;
            end
            default: next_state_s = ST_LOAD_A;
        endcase
    end

    // Operand capture, multiplier iteration and result/overflow registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            a_r      <= 8'd0;
            b_r      <= 8'd0;
            op_r     <= 2'd0;
            mcand_r  <= 16'd0;
            mplr_r   <= 9'd0;
            acc_r    <= 16'd0;
            cnt_r    <= 4'd0;
            neg_r    <= 1'b0;
            result_r <= 8'd0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD_A: begin
                    if (press_s) begin
                        a_r   <= bus.SW;
                        ovf_r <= 1'b0;
                    end
                end
                ST_LOAD_B: begin
                    if (press_s) begin
                        b_r     <= bus.SW;
                        op_r    <= bus.OP;
                        mcand_r <= {7'd0, abs9(a_r)};
                        mplr_r  <= abs9(bus.SW);
                        acc_r   <= 16'd0;
                        cnt_r   <= 4'd0;
                        neg_r   <= a_r[7] ^ bus.SW[7];
                    end
                end
                ST_EXEC: begin
                    {ovf_r, result_r} <= sat9(exec_sum_s);
                end
                ST_MUL: begin
                    acc_r   <= acc_step_s;
                    mcand_r <= mcand_r << 1;
                    mplr_r  <= mplr_r >> 1;
                    cnt_r   <= cnt_r + 4'd1;
                    if (mul_last_s) begin
                        {ovf_r, result_r} <= sat_mag(acc_step_s, neg_r);
                    end
                end
                ST_DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    // Output select: live switch echo while entering, held result otherwise;
    // forced to zero whenever reset is asserted so no partial value escapes.
    always_comb begin
        result_s = result_r;
        if (!RESET_N) begin
            result_s = 8'd0;
        end else if (state_r == ST_LOAD_A || state_r == ST_LOAD_B) begin
            result_s = bus.SW;
        end else begin
            result_s = result_r;
        end
    end

    // Phase code for the LEDs; EXEC and MUL share one code.
    always_comb begin
        phase_s = 2'b00;
        case (state_r)
            ST_LOAD_A: phase_s = 2'b00;
            ST_LOAD_B: phase_s = 2'b01;
            ST_EXEC:   phase_s = 2'b10;
            ST_MUL:    phase_s = 2'b10;
            ST_DONE:   phase_s = 2'b11;
            default:   phase_s = 2'b00;
        endcase
    end

    assign bus.RESULT = result_s;
    assign bus.OVF    = ovf_r;
    assign bus.BUSY   = (state_r == ST_MUL);
    assign bus.PHASE  = phase_s;

endmodule

// File: tb/tb_calc_core.sv
// Directed self-checking bench for calc_core.
module tb_calc_core;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    calc_core_if bus_if();

    calc_core #(
        .SYNC_STAGES (2),
        .MUL_STEPS   (8)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn();
        bus_if.ENTER_N = 1'b0;
        cyc(4);
        bus_if.ENTER_N = 1'b1;
        cyc(4);
    endtask

    task automatic wait_phase(input logic [1:0] ph, input int budget, input string tag);
        int n;
        n = 0;
        while (bus_if.PHASE !== ph && n < budget) begin
            cyc(1);
            n++;
        end
        check_val(tag, {14'd0, bus_if.PHASE}, {14'd0, ph});
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] exp_res, input logic exp_ovf);
        bus_if.SW = a;
        #1;
        check_val({tag, "_echo"}, {8'd0, bus_if.RESULT}, {8'd0, a});
        press_btn();
        check_val({tag, "_ph_b"}, {14'd0, bus_if.PHASE}, 16'd1);
        check_val({tag, "_ovf_b"}, {15'd0, bus_if.OVF}, 16'd0);
        bus_if.SW = b;
        bus_if.OP = op;
        press_btn();
        bus_if.SW = 8'h3C;
        bus_if.OP = 2'b01;
        wait_phase(2'b11, 40, {tag, "_done"});
        check_val({tag, "_res"}, {8'd0, bus_if.RESULT}, {8'd0, exp_res});
        check_val({tag, "_ovf"}, {15'd0, bus_if.OVF}, {15'd0, exp_ovf});
        press_btn();
        check_val({tag, "_ph_a"}, {14'd0, bus_if.PHASE}, 16'd0);
        check_val({tag, "_ovf_keep"}, {15'd0, bus_if.OVF}, {15'd0, exp_ovf});
    endtask

    initial begin
        int lat;
        int busy_cnt;

        rst_n          = 1'b0;
        bus_if.SW      = 8'h5A;
        bus_if.OP      = 2'b00;
        bus_if.ENTER_N = 1'b1;
        #1;
        check_val("rst_result", {8'd0, bus_if.RESULT}, 16'h0000);
        check_val("rst_ovf",    {15'd0, bus_if.OVF},   16'd0);
        check_val("rst_busy",   {15'd0, bus_if.BUSY},  16'd0);
        check_val("rst_phase",  {14'd0, bus_if.PHASE}, 16'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Reset while in LOAD_B
        bus_if.SW = 8'h11;
        press_btn();
        bus_if.SW = 8'h55;
        #1;
        check_val("ldb_echo", {8'd0, bus_if.RESULT}, 16'h0055);
        rst_n = 1'b0;
        #1;
        check_val("rstb_result", {8'd0, bus_if.RESULT}, 16'h0000);
        check_val("rstb_ovf",    {15'd0, bus_if.OVF},   16'd0);
        check_val("rstb_busy",   {15'd0, bus_if.BUSY},  16'd0);
        check_val("rstb_phase",  {14'd0, bus_if.PHASE}, 16'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check_val("rstb_echo",   {8'd0, bus_if.RESULT}, 16'h0055);
        check_val("rstb_phase2", {14'd0, bus_if.PHASE}, 16'd0);

        // Single-cycle operations and saturation edges
        run_op("add",     8'h14, 8'hF6, 2'b00, 8'h0A, 1'b0);
        run_op("add_sat", 8'h64, 8'h64, 2'b00, 8'h7F, 1'b1);
        run_op("sub_sat", 8'h80, 8'h01, 2'b01, 8'h80, 1'b1);
        run_op("sub",     8'h05, 8'h09, 2'b01, 8'hFC, 1'b0);
        run_op("neg_sat", 8'h80, 8'h33, 2'b11, 8'h7F, 1'b1);
        run_op("neg",     8'h05, 8'h00, 2'b11, 8'hFB, 1'b0);

        // Multiply with latency/BUSY measurement and an ignored press mid-MUL
        bus_if.SW = 8'hF9;
        press_btn();
        bus_if.SW      = 8'h06;
        bus_if.OP      = 2'b10;
        bus_if.ENTER_N = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (bus_if.PHASE !== 2'b11 && lat < 60) begin
            cyc(1);
            lat++;
            if (lat == 3) bus_if.ENTER_N = 1'b1;
            if (lat == 5) bus_if.ENTER_N = 1'b0;
            if (lat == 7) bus_if.ENTER_N = 1'b1;
            if (bus_if.BUSY === 1'b1) busy_cnt++;
        end
        check_val("mul_latency", lat[15:0], 16'd11);
        check_val("mul_busy",    busy_cnt[15:0], 16'd8);
        cyc(5);
        check_val("mul_ignore_ph", {14'd0, bus_if.PHASE}, 16'd3);
        check_val("mul_res",       {8'd0, bus_if.RESULT}, 16'h00D6);
        check_val("mul_ovf",       {15'd0, bus_if.OVF},   16'd0);
        press_btn();
        check_val("mul_ph_a",      {14'd0, bus_if.PHASE}, 16'd0);

        run_op("mul_sat",  8'h80, 8'hFF, 2'b10, 8'h7F, 1'b1);
        run_op("mul_zero", 8'h00, 8'hFB, 2'b10, 8'h00, 1'b0);
        run_op("mul_min",  8'h80, 8'h01, 2'b10, 8'h80, 1'b0);

        // Held button advances exactly once
        bus_if.SW      = 8'h21;
        bus_if.ENTER_N = 1'b0;
        cyc(1000);
        check_val("hold_ph", {14'd0, bus_if.PHASE}, 16'd1);
        bus_if.ENTER_N = 1'b1;
        cyc(4);
        check_val("hold_ph2", {14'd0, bus_if.PHASE}, 16'd1);
        bus_if.SW = 8'h02;
        bus_if.OP = 2'b00;
        press_btn();
        wait_phase(2'b11, 40, "hold_done");
        check_val("hold_res", {8'd0, bus_if.RESULT}, 16'h0023);
        press_btn();

        // Reset in the middle of a multiply
        bus_if.SW = 8'h0B;
        press_btn();
        bus_if.SW      = 8'h09;
        bus_if.OP      = 2'b10;
        bus_if.ENTER_N = 1'b0;
        cyc(3);
        bus_if.ENTER_N = 1'b1;
        cyc(4);
        check_val("rstm_busy_pre", {15'd0, bus_if.BUSY}, 16'd1);
        rst_n = 1'b0;
        #1;
        check_val("rstm_result", {8'd0, bus_if.RESULT}, 16'h0000);
        check_val("rstm_busy",   {15'd0, bus_if.BUSY},  16'd0);
        check_val("rstm_phase",  {14'd0, bus_if.PHASE}, 16'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        run_op("mul_after_rst", 8'h0B, 8'h09, 2'b10, 8'h63, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
